// File: rtl/div12_monitor_pkg.sv
// Shared definitions for the divide-by-12 toggle monitor: FSM encoding and
// the default timing constants shared with the mod-6 counter block.
package div12_monitor_pkg;

   // Receiver FSM: hunt for a first edge, check spacing, then hold lock.
   typedef enum logic [1:0] {
      ST_SEARCH = 2'b00,
      ST_TRACK  = 2'b01,
      ST_LOCKED = 2'b10
   } state_e;

   // Half-period of the divide-by-12 toggle, in clk cycles.
   localparam int DEF_HALF   = 6;
   // Consecutive good edges before lock is declared.
   localparam int DEF_LOCK_N = 4;
   // Width of the edge-spacing counter and the phase output.
   localparam int DEF_CW     = 3;
   // Width of the good-edge run counter (holds LOCK_N up to 15).
   localparam int GOOD_W     = 4;
   // Width of the error counter.
   localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/div12_monitor_sat.sv
// Saturating up-counter with synchronous clear. Used for the good-edge run
// length and for the error tally.
module sat_counter
   import div12_monitor_pkg::*;
#(
   parameter int W   = GOOD_W,
   parameter int MAX = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] count_reg;

   // Clear wins over increment; increment stops once MAX is reached.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != MAX_V)) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/div12_monitor.sv
// Receiver-side checker for the divide-by-12 toggle. Detects edges on y_in,
// rebuilds the transmitter's phase, declares lock after a run of correctly
// spaced edges and flags early or missing edges.
module div12_monitor
   import div12_monitor_pkg::*;
#(
   parameter int HALF   = DEF_HALF,
   parameter int LOCK_N = DEF_LOCK_N,
   parameter int CW     = DEF_CW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 y_in,
   output logic                 edge_pulse,
   output logic [CW-1:0]        phase,
   output logic                 locked,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [CW-1:0]     CNT_MAX   = CW'(HALF - 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);

   logic              y_d_reg;
   state_e            state_reg, state_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic              err_reg, err_next;
   logic              good_clr, good_inc;
   logic [GOOD_W-1:0] good;
   logic              at_max;

   assign edge_pulse = y_in ^ y_d_reg;
   assign at_max     = (cnt_reg == CNT_MAX);

   // Spacing counter: restart after every edge, otherwise count up and hold
   // at HALF-1 (in TRACK/LOCKED that value always ends in an edge or a timeout).
   always_comb begin
      cnt_next = cnt_reg;
      if (edge_pulse) begin
         cnt_next = '0;
      end else if (!at_max) begin
         cnt_next = cnt_reg + CW'(1);
      end
   end

   // Lock FSM: classify each edge (or its absence) against the expected spacing.
   always_comb begin
      state_next = state_reg;
      err_next   = 1'b0;
      good_clr   = 1'b0;
      good_inc   = 1'b0;
      case (state_reg)
         ST_SEARCH: begin
            if (edge_pulse) begin
               state_next = ST_TRACK;
               good_clr   = 1'b1;
            end
         end
         ST_TRACK, ST_LOCKED: begin
            if (edge_pulse) begin
               if (at_max) begin
                  good_inc = 1'b1;
                  if (good >= GOOD_LAST) begin
                     state_next = ST_LOCKED;
                  end
               end else begin
                  // Early edge becomes the new reference point.
                  err_next   = 1'b1;
                  good_clr   = 1'b1;
                  state_next = ST_TRACK;
               end
            end else if (at_max) begin
               // Expected edge never came: start hunting again.
               err_next   = 1'b1;
               good_clr   = 1'b1;
               state_next = ST_SEARCH;
            end
         end
         default: begin
            state_next = ST_SEARCH;
            good_clr   = 1'b1;
         end
      endcase
   end

   // Registered state, edge reference and error pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_d_reg   <= 1'b0;
         state_reg <= ST_SEARCH;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         y_d_reg   <= y_in;
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   sat_counter #(
      .W   (GOOD_W),
      .MAX (LOCK_N)
   ) u_good (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (good_clr),
      .inc   (good_inc),
      .count (good)
   );

   sat_counter #(
      .W   (ERR_CNT_W),
      .MAX ((1 << ERR_CNT_W) - 1)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .inc   (err_next),
      .count (err_cnt)
   );

   assign locked = (state_reg == ST_LOCKED);
   assign phase  = cnt_reg;
   assign err    = err_reg;

endmodule

// File: tb/tb_div12_monitor.sv
// Bench for div12_monitor: three instances (default, LOCK_N=1, HALF=8) share
// one toggle stream; each is compared every cycle against a timestamp-based
// reference model of the edge-spacing rules.
module tb_div12_monitor;

   localparam int NI = 3;
   localparam int HALF_P [NI] = '{6, 6, 8};
   localparam int LOCK_P [NI] = '{4, 1, 4};

   logic clk = 1'b0;
   logic rst_n;
   logic y;

   logic [NI-1:0] edge_o, locked_o, err_o;
   logic [2:0]    phase_o [NI];
   logic [7:0]    errc_o  [NI];

   always #5 clk = ~clk;

   div12_monitor #(.HALF(6), .LOCK_N(4), .CW(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .y_in(y), .edge_pulse(edge_o[0]),
      .phase(phase_o[0]), .locked(locked_o[0]), .err(err_o[0]), .err_cnt(errc_o[0])
   );

   div12_monitor #(.HALF(6), .LOCK_N(1), .CW(3)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .y_in(y), .edge_pulse(edge_o[1]),
      .phase(phase_o[1]), .locked(locked_o[1]), .err(err_o[1]), .err_cnt(errc_o[1])
   );

   div12_monitor #(.HALF(8), .LOCK_N(4), .CW(3)) u_dut_h8 (
      .clk(clk), .rst_n(rst_n), .y_in(y), .edge_pulse(edge_o[2]),
      .phase(phase_o[2]), .locked(locked_o[2]), .err(err_o[2]), .err_cnt(errc_o[2])
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: time-stamp of the reference edge instead of a counter.
   bit m_search [NI];
   int m_ref    [NI];
   int m_good   [NI];
   bit m_locked [NI];
   bit m_err    [NI];
   int m_errc   [NI];
   bit m_rst    [NI];
   bit m_yprev;

   task automatic check(string tag, int got, int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   // Advance the model of instance k by one clk cycle.
   task automatic model_step(int k, bit e, bit run);
      int d;
      if (!run) begin
         m_search[k] = 1'b1;
         m_ref[k]    = 0;
         m_good[k]   = 0;
         m_locked[k] = 1'b0;
         m_err[k]    = 1'b0;
         m_errc[k]   = 0;
         m_rst[k]    = 1'b1;
      end else begin
         m_rst[k] = 1'b0;
         m_err[k] = 1'b0;
         if (m_search[k]) begin
            if (e) begin
               m_search[k] = 1'b0;
               m_ref[k]    = cyc;
               m_good[k]   = 0;
            end
         end else begin
            d = cyc - m_ref[k];
            if (e) begin
               if (d == HALF_P[k]) begin
                  if (m_good[k] < LOCK_P[k]) m_good[k]++;
                  if (m_good[k] == LOCK_P[k]) m_locked[k] = 1'b1;
               end else begin
                  m_err[k]    = 1'b1;
                  m_good[k]   = 0;
                  m_locked[k] = 1'b0;
               end
               m_ref[k] = cyc;
            end else if (d == HALF_P[k]) begin
               m_err[k]    = 1'b1;
               m_good[k]   = 0;
               m_locked[k] = 1'b0;
               m_search[k] = 1'b1;
            end
         end
         if (m_err[k] && m_errc[k] < 255) m_errc[k]++;
      end
   endtask

   // Compare every instance against the model state for the current cycle.
   task automatic compare_all();
      for (int k = 0; k < NI; k++) begin
         check($sformatf("edge[%0d]", k), int'(edge_o[k]), int'(y ^ m_yprev));
         check($sformatf("locked[%0d]", k), int'(locked_o[k]), int'(m_locked[k]));
         check($sformatf("err[%0d]", k), int'(err_o[k]), int'(m_err[k]));
         check($sformatf("err_cnt[%0d]", k), int'(errc_o[k]), m_errc[k]);
         if (m_rst[k])
            check($sformatf("phase_rst[%0d]", k), int'(phase_o[k]), 0);
         else if (m_locked[k])
            check($sformatf("phase[%0d]", k), int'(phase_o[k]), cyc - m_ref[k] - 1);
      end
   endtask

   // One clk cycle: drive, sample on the falling edge, step the model.
   task automatic cycle(bit yv, bit rv);
      y     = yv;
      rst_n = rv;
      @(negedge clk);
      compare_all();
      for (int k = 0; k < NI; k++) model_step(k, y ^ m_yprev, rv);
      m_yprev = rv ? y : 1'b0;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // n toggles spaced g cycles apart.
   task automatic gaps(int g, int n);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < g - 1; j++) cycle(y, 1'b1);
         cycle(~y, 1'b1);
      end
   endtask

   task automatic hold(int n);
      for (int i = 0; i < n; i++) cycle(y, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      y     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) model_step(k, 1'b0, 1'b0);
      m_yprev = 1'b0;

      // Clean lock and 200+ cycles of free running.
      gaps(6, 12);
      check("clean_locked", int'(locked_o[0]), 1);
      gaps(6, 35);
      check("clean_err_cnt", int'(errc_o[0]), 0);

      // Early edge while locked, then re-lock.
      gaps(3, 1);
      gaps(6, 8);
      check("early_relock", int'(locked_o[0]), 1);

      // Missing edge: hold, then resume.
      hold(10);
      gaps(6, 8);

      // Reset mid-lock, then re-lock.
      cycle(y, 1'b0);
      gaps(6, 8);
      check("reset_relock", int'(locked_o[0]), 1);

      // Longer spacing: HALF=8 instance locks, then 7-cycle spacing errs.
      gaps(8, 10);
      check("half8_locked", int'(locked_o[2]), 1);
      gaps(7, 6);

      // Error counter saturation.
      gaps(3, 300);
      check("err_cnt_sat", int'(errc_o[0]), 255);

      // Random spacing with occasional resets.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 29) == 0) cycle(y, 1'b0);
         else gaps(int'($urandom_range(2, 10)), 1);
      end
      gaps(6, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
